// File: rtl/me_full_search.sv
// Full-search motion estimation: streams cur/ref rows per candidate over a +/-R window,
// tracks the minimum saturating SAD and its motion vector, with optional early exit.
module me_full_search #(
    parameter int MACRO_DIM    = 4,
    parameter int SEARCH_RANGE = 8,
    parameter int PIXEL_W      = 8,
    parameter int SAD_W        = 16,
    parameter int MV_W         = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           early_en,
    input  logic [SAD_W-1:0]               early_thresh,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [MACRO_DIM*PIXEL_W-1:0]   cur_row,
    input  logic [MACRO_DIM*PIXEL_W-1:0]   ref_row,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SAD_W-1:0]               min_sad,
    output logic [MV_W-1:0]                mv_x,
    output logic [MV_W-1:0]                mv_y,
    output logic [15:0]                    cand_count,
    output logic                           early_hit
);
    localparam int RW    = $clog2(MACRO_DIM);
    localparam int SUM_W = PIXEL_W + $clog2(MACRO_DIM) + 1;
    localparam int EXT_W = ((SAD_W > SUM_W) ? SAD_W : SUM_W) + 1;
    localparam logic [SAD_W-1:0]       MAXV     = '1;
    localparam logic [RW-1:0]          LAST_ROW = RW'(MACRO_DIM - 1);
    localparam logic signed [MV_W-1:0] RPOS     = MV_W'(SEARCH_RANGE);
    localparam logic signed [MV_W-1:0] RNEG     = -RPOS;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [RW-1:0]           row_q, row_d;
    logic signed [MV_W-1:0]  dx_q, dx_d, dy_q, dy_d;
    logic [SAD_W-1:0]        acc_q, acc_d, min_q, min_d, thr_q, thr_d;
    logic [MV_W-1:0]         mvx_q, mvx_d, mvy_q, mvy_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    hit_q, hit_d, een_q, een_d;
    logic [SUM_W-1:0]        row_sad;
    logic [SAD_W-1:0]        cand_sad;

    function automatic logic [SAD_W-1:0] sat_add(input logic [SAD_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        logic [EXT_W-1:0] s;
        s = EXT_W'(a) + EXT_W'(b);
        return (s > EXT_W'(MAXV)) ? MAXV : s[SAD_W-1:0];
    endfunction

    always_comb begin
        row_sad = '0;
        for (int i = 0; i < MACRO_DIM; i++) begin
            logic [PIXEL_W-1:0] c, r;
            c = cur_row[i*PIXEL_W +: PIXEL_W];
            r = ref_row[i*PIXEL_W +: PIXEL_W];
            row_sad = row_sad + SUM_W'((c > r) ? (c - r) : (r - c));
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        acc_d    = acc_q;
        min_d    = min_q;
        mvx_d    = mvx_q;
        mvy_d    = mvy_q;
        cnt_d    = cnt_q;
        hit_d    = hit_q;
        een_d    = een_q;
        thr_d    = thr_q;
        cand_sad = '0;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                row_d   = '0;
                dx_d    = RNEG;
                dy_d    = RNEG;
                acc_d   = '0;
                min_d   = MAXV;
                mvx_d   = '0;
                mvy_d   = '0;
                cnt_d   = '0;
                hit_d   = 1'b0;
                een_d   = early_en;
                thr_d   = early_thresh;
            end
            RUN: if (in_valid) begin
                if (row_q != LAST_ROW) begin
                    acc_d = sat_add(acc_q, row_sad);
                    row_d = row_q + RW'(1);
                end else begin
                    cand_sad = sat_add(acc_q, row_sad);
                    acc_d    = '0;
                    row_d    = '0;
                    cnt_d    = cnt_q + 16'd1;
                    // First candidate always seeds the minimum so a fully saturated
                    // window still reports the first position rather than (0,0).
                    if (cnt_q == 16'd0 || cand_sad < min_q) begin
                        min_d = cand_sad;
                        mvx_d = dx_q;
                        mvy_d = dy_q;
                    end
                    if (dx_q == RPOS) begin
                        dx_d = RNEG;
                        dy_d = dy_q + MV_W'(1);
                    end else begin
                        dx_d = dx_q + MV_W'(1);
                    end
                    if (een_q && cand_sad < thr_q) begin
                        hit_d   = 1'b1;
                        state_d = DONE;
                    end else if (dx_q == RPOS && dy_q == RPOS) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            acc_q   <= '0;
            min_q   <= '0;
            mvx_q   <= '0;
            mvy_q   <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            een_q   <= 1'b0;
            thr_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            acc_q   <= acc_d;
            min_q   <= min_d;
            mvx_q   <= mvx_d;
            mvy_q   <= mvy_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            een_q   <= een_d;
            thr_q   <= thr_d;
        end
    end

    assign in_ready   = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign min_sad    = min_q;
    assign mv_x       = mvx_q;
    assign mv_y       = mvy_q;
    assign cand_count = cnt_q;
    assign early_hit  = hit_q;
endmodule

// File: tb/tb_me_full_search.sv
// Scoreboarded directed bench for me_full_search (R=1, 4x4 blocks), plus an 8-bit-SAD
// instance sharing the same stimulus to exercise saturation.
module tb_me_full_search;
    logic        clk = 0, rst = 1, start = 0, early_en = 0, in_valid = 0, out_ready = 1;
    logic [15:0] early_thresh = '0;
    logic [31:0] cur_row = '0, ref_row = '0;

    logic        in_ready, busy, out_valid, early_hit;
    logic [15:0] min_sad, cand_count;
    logic [5:0]  mv_x, mv_y;

    logic        s_in_ready, s_busy, s_out_valid, s_early_hit;
    logic [7:0]  s_min_sad;
    logic [15:0] s_cand_count;
    logic [5:0]  s_mv_x, s_mv_y;

    me_full_search #(.MACRO_DIM(4), .SEARCH_RANGE(1), .PIXEL_W(8), .SAD_W(16), .MV_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .early_en(early_en), .early_thresh(early_thresh),
        .in_valid(in_valid), .in_ready(in_ready), .cur_row(cur_row), .ref_row(ref_row),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .min_sad(min_sad),
        .mv_x(mv_x), .mv_y(mv_y), .cand_count(cand_count), .early_hit(early_hit));

    me_full_search #(.MACRO_DIM(4), .SEARCH_RANGE(1), .PIXEL_W(8), .SAD_W(8), .MV_W(6)) u_sat (
        .clk(clk), .rst(rst), .start(start), .early_en(early_en), .early_thresh(early_thresh[7:0]),
        .in_valid(in_valid), .in_ready(s_in_ready), .cur_row(cur_row), .ref_row(ref_row),
        .busy(s_busy), .out_valid(s_out_valid), .out_ready(out_ready), .min_sad(s_min_sad),
        .mv_x(s_mv_x), .mv_y(s_mv_y), .cand_count(s_cand_count), .early_hit(s_early_hit));

    always #5 clk = ~clk;

    typedef struct {int sad; int mx; int my; int cnt; int hit;} exp_t;
    exp_t qm[$], qs[$];
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int sad, input int mx, input int my, input int cnt, input int hit);
        exp_t e;
        e.sad = sad; e.mx = mx; e.my = my; e.cnt = cnt; e.hit = hit;
        return e;
    endfunction

    // Main monitor: pop on the first DONE cycle, then require held outputs.
    logic m_prev = 0;
    exp_t m_held;
    always @(negedge clk) begin
        if (out_valid && !m_prev) begin
            if (qm.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                exp_t e;
                e = qm.pop_front();
                chk("min_sad", int'(min_sad), e.sad);
                chk("mv_x", int'($signed(mv_x)), e.mx);
                chk("mv_y", int'($signed(mv_y)), e.my);
                chk("cand_count", int'(cand_count), e.cnt);
                chk("early_hit", int'(early_hit), e.hit);
                chk("in_ready_in_done", int'(in_ready), 0);
                m_held = mk(int'(min_sad), int'($signed(mv_x)), int'($signed(mv_y)),
                            int'(cand_count), int'(early_hit));
            end
        end else if (out_valid && m_prev) begin
            chk("hold_min_sad", int'(min_sad), m_held.sad);
            chk("hold_mv_x", int'($signed(mv_x)), m_held.mx);
            chk("hold_mv_y", int'($signed(mv_y)), m_held.my);
            chk("hold_cand_count", int'(cand_count), m_held.cnt);
        end
        m_prev = out_valid;
    end

    logic s_prev = 0;
    always @(negedge clk) begin
        if (s_out_valid && !s_prev) begin
            if (qs.size() == 0) chk("sat_unexpected_result", 1, 0);
            else begin
                exp_t e;
                e = qs.pop_front();
                chk("sat_min_sad", int'(s_min_sad), e.sad);
                chk("sat_mv_x", int'($signed(s_mv_x)), e.mx);
                chk("sat_mv_y", int'($signed(s_mv_y)), e.my);
                chk("sat_cand_count", int'(s_cand_count), e.cnt);
            end
        end
        s_prev = s_out_valid;
    end

    task automatic pulse_start;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        chk("busy_after_start", int'(busy), 1);
        chk("in_ready_after_start", int'(in_ready), 1);
    endtask

    // Streams candidates; candidate `best` gets ref pixel rbest, others rdef.
    task automatic run(input int ncand, input int best, input logic [7:0] cpx,
                       input logic [7:0] rdef, input logic [7:0] rbest,
                       input bit gaps, input int max_beats);
        int beats = 0;
        for (int c = 0; c < ncand; c++) begin
            for (int r = 0; r < 4; r++) begin
                bit got;
                int t;
                if (beats >= max_beats) begin
                    in_valid = 0;
                    return;
                end
                if (gaps && $urandom_range(0, 2) == 0) begin
                    in_valid = 0;
                    @(posedge clk); #1;
                end
                in_valid = 1;
                cur_row  = {4{cpx}};
                ref_row  = (c == best) ? {4{rbest}} : {4{rdef}};
                if (gaps && r == 0 && (c == 1 || c == 5)) start = 1;
                got = 0;
                t = 0;
                while (!got) begin
                    @(negedge clk);
                    got = in_ready;
                    @(posedge clk); #1;
                    t++;
                    if (t > 200) begin
                        chk("beat_timeout", 1, 0);
                        in_valid = 0;
                        start = 0;
                        return;
                    end
                end
                start = 0;
                beats++;
            end
        end
        in_valid = 0;
    endtask

    task automatic wait_idle(input int hold);
        int t = 0;
        if (hold > 0) begin
            while (!out_valid && t < 500) begin @(negedge clk); t++; end
            repeat (hold) @(negedge clk);
            out_ready = 1;
        end
        t = 0;
        while ((busy || s_busy) && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) chk("idle_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_min_sad", int'(min_sad), 0);
        chk("rst_cand_count", int'(cand_count), 0);
        @(negedge clk); rst = 0;

        // Best candidate at index 7 -> (0,+1)
        qm.push_back(mk(0, 0, 1, 9, 0)); qs.push_back(mk(0, 0, 1, 9, 0));
        pulse_start();
        run(9, 7, 8'd100, 8'd110, 8'd100, 0, 1000);
        wait_idle(0);

        // All ties: first candidate (-1,-1) wins
        qm.push_back(mk(160, -1, -1, 9, 0)); qs.push_back(mk(160, -1, -1, 9, 0));
        pulse_start();
        run(9, -1, 8'd100, 8'd110, 8'd110, 0, 1000);
        wait_idle(0);

        // Early termination at candidate 2 -> (+1,-1)
        early_en = 1; early_thresh = 16'd10;
        qm.push_back(mk(0, 1, -1, 3, 1)); qs.push_back(mk(0, 1, -1, 3, 1));
        pulse_start();
        early_en = 0; early_thresh = 16'd0;
        run(3, 2, 8'd100, 8'd110, 8'd100, 0, 1000);
        chk("early_in_ready_drop", int'(in_ready), 0);
        chk("early_out_valid", int'(out_valid), 1);
        wait_idle(0);

        // Back-pressure: gapped beats, stray starts, out_ready low for 5 cycles
        out_ready = 0;
        qm.push_back(mk(0, 0, 1, 9, 0)); qs.push_back(mk(0, 0, 1, 9, 0));
        pulse_start();
        run(9, 7, 8'd100, 8'd110, 8'd100, 1, 1000);
        wait_idle(5);

        // Saturation: 4080 fits 16 bits, clamps to 255 on the 8-bit instance
        qm.push_back(mk(4080, -1, -1, 9, 0)); qs.push_back(mk(255, -1, -1, 9, 0));
        pulse_start();
        run(9, -1, 8'd255, 8'd0, 8'd0, 0, 1000);
        wait_idle(0);

        // Reset mid-RUN after 10 beats discards the partial search
        pulse_start();
        run(9, 7, 8'd100, 8'd110, 8'd100, 0, 10);
        #2 rst = 1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_min_sad", int'(min_sad), 0);
        chk("midrst_mv_x", int'(mv_x), 0);
        chk("midrst_mv_y", int'(mv_y), 0);
        chk("midrst_cand_count", int'(cand_count), 0);
        @(negedge clk); rst = 0;
        qm.push_back(mk(0, 0, 1, 9, 0)); qs.push_back(mk(0, 0, 1, 9, 0));
        pulse_start();
        run(9, 7, 8'd100, 8'd110, 8'd100, 0, 1000);
        wait_idle(0);

        repeat (3) @(negedge clk);
        chk("queue_main_empty", qm.size(), 0);
        chk("queue_sat_empty", qs.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
